// File: rtl/regfile_bank_if.sv
// rtl/regfile_bank_if.sv - write/read/clear bus bundle for the register bank
interface regfile_bank_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
);
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH/8-1:0] wbe;
   logic [AW-1:0]    raddr0;
   logic [AW-1:0]    raddr1;
   logic [WIDTH-1:0] rdata0;
   logic [WIDTH-1:0] rdata1;
   logic             clr;
   logic             busy;
   logic             wr_drop;

   modport master (
      output we, waddr, wdata, wbe, raddr0, raddr1, clr,
      input  rdata0, rdata1, busy, wr_drop
   );

   modport slave (
      input  we, waddr, wdata, wbe, raddr0, raddr1, clr,
      output rdata0, rdata1, busy, wr_drop
   );
endinterface

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - byte-enabled register bank with bypass, zero entry and clear sweep
module regfile_bank #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   regfile_bank_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = WIDTH / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic             drop_q, drop_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] merged_word;
   logic             write_hits_zero;
   logic             bypass_on;

   function automatic logic [WIDTH-1:0] byte_merge(
      input logic [WIDTH-1:0] old_w,
      input logic [WIDTH-1:0] new_w,
      input logic [NB-1:0]    be
   );
      byte_merge = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) byte_merge[8*i +: 8] = new_w[8*i +: 8];
      end
   endfunction

   // Word that a write in this cycle would leave behind; shared by the write and bypass paths
   always_comb begin
      merged_word     = byte_merge(mem_q[bus.waddr], bus.wdata, bus.wbe);
      write_hits_zero = (ZERO_REG != 0) && (bus.waddr == '0);
      bypass_on       = (BYPASS != 0) && (state_q == IDLE) && bus.we;
   end

   // Next-state: accept writes and start sweeps in IDLE, zero one entry per cycle in CLEAR
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      drop_d  = 1'b0;
      mem_d   = mem_q;
      case (state_q)
         IDLE: begin
            if (bus.we && !write_hits_zero) mem_d[bus.waddr] = merged_word;
            if (bus.clr) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            mem_d[ptr_q] = '0;
            ptr_d        = ptr_q + 1'b1;
            drop_d       = bus.we;
            if (ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset clears the whole array without waiting for a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         drop_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
         mem_q   <= mem_d;
      end
   end

   // Read ports: zero entry overrides bypass, bypass overrides stored contents
   always_comb begin
      if ((ZERO_REG != 0) && (bus.raddr0 == '0))       bus.rdata0 = '0;
      else if (bypass_on && (bus.raddr0 == bus.waddr)) bus.rdata0 = merged_word;
      else                                             bus.rdata0 = mem_q[bus.raddr0];

      if ((ZERO_REG != 0) && (bus.raddr1 == '0))       bus.rdata1 = '0;
      else if (bypass_on && (bus.raddr1 == bus.waddr)) bus.rdata1 = merged_word;
      else                                             bus.rdata1 = mem_q[bus.raddr1];
   end

   // Status outputs come straight from flops
   always_comb begin
      bus.busy    = (state_q == CLEAR);
      bus.wr_drop = drop_q;
   end
endmodule
